buf_req_ctrl: RTL and testbench
===============================

Name: buf_req_ctrl

Overview:
- Request front-end that sits directly upstream of lfu_finder in the 4-entry buffer manager.
- Accepts tag lookups over a valid/ready handshake and holds one tag register plus a valid bit per buffer.
- On a hit it reports the buffer index to lfu_finder (ref_buf_req / ref_vld).
- On a miss it fills a free buffer if one exists. Otherwise it pulses new_buf_req, takes lfu_finder's buf_num_replc as the victim, runs a fill handshake to memory and returns a response.

Parameters:
BUF_BIT, 2, buffer index width; NUM_BUF = 2**BUF_BIT entries (derived, not overridable)
TAG_W, 8, request tag width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_vld  input  1  lookup request valid
req_tag  input  TAG_W  tag to look up
req_rdy  output  1  block can accept a request
rsp_vld  output  1  response valid
rsp_hit  output  1  1 = hit, 0 = filled after miss
rsp_idx  output  BUF_BIT  buffer index serving the request
rsp_rdy  input  1  consumer accepts response
ref_vld  output  1  one-cycle pulse, hit reported to lfu_finder
ref_buf_req  output  BUF_BIT  index of last hit; holds its value between hits
new_buf_req  output  1  one-cycle pulse requesting an LFU victim
buf_num_replc  input  BUF_BIT  victim index from lfu_finder
fill_req  output  1  memory fill request, level
fill_tag  output  TAG_W  tag being filled
fill_idx  output  BUF_BIT  destination buffer
fill_ack  input  1  one-cycle fill completion

Behaviour:
- Reset (async, rst_n=0), all values below take effect immediately:
  - State = IDLE; all valid bits = 0; tags = 0.
  - req_rdy=1; rsp_vld=0, rsp_hit=0, rsp_idx=0.
  - ref_vld=0, ref_buf_req=0; new_buf_req=0.
  - fill_req=0, fill_tag=0, fill_idx=0.
- Reset mid-operation aborts everything:
  - fill_req drops immediately.
  - A fill_ack arriving after reset is ignored.
  - No response is produced for the aborted request.
- FSM states: IDLE, CHECK, VICT, FILL, RESP. All outputs are registered.
- IDLE:
  - req_rdy=1.
  - On req_vld&req_rdy at edge k: latch req_tag, go to CHECK.
  - req_rdy=0 in every other state, so only one request is in flight.
- CHECK (cycle k+1): compare the latched tag against all valid entries.
  - Hit at index i → at edge k+2: ref_vld=1 for one cycle, ref_buf_req=i, rsp_hit=1, rsp_idx=i, go to RESP. Hit latency is 2 cycles from acceptance to rsp_vld.
  - Miss, any entry invalid → victim = lowest-numbered invalid index; go to FILL. new_buf_req is not asserted.
  - Miss, all entries valid → new_buf_req=1 at edge k+2, go to VICT.
  - Duplicate valid tags cannot occur. If they do, the lowest index wins.
- VICT:
  - new_buf_req is high for exactly one cycle.
  - buf_num_replc is sampled at the edge where new_buf_req falls (k+3); that value is the victim.
  - Go to FILL.
- FILL:
  - fill_req=1, fill_tag = latched tag, fill_idx = victim. These hold stable until fill_ack.
  - On fill_ack: tag[victim] = latched tag, valid[victim] = 1, fill_req=0, rsp_hit=0, rsp_idx = victim, go to RESP.
  - fill_ack seen in any state other than FILL is ignored.
- RESP:
  - rsp_vld=1; rsp_* hold stable until rsp_rdy.
  - On rsp_vld&rsp_rdy: rsp_vld=0, go to IDLE; req_rdy=1 the next cycle.
  - Back-to-back requests are separated by at least one IDLE cycle.
- Victim rules:
  - A victim that is currently valid is overwritten (its old tag is discarded).
  - Overwriting does not pulse ref_vld; the counter in lfu_finder is reset by lfu_finder itself.
- req_vld is ignored while req_rdy=0; requesters must hold the request until accepted.

Test Plan:
- Reset, then requests tag 0x11, 0x22, 0x33, 0x44 with fill_ack 3 cycles after each fill_req:
  - fill_idx = 0, 1, 2, 3 in order.
  - new_buf_req never pulses.
  - rsp_hit=0 each time, with rsp_idx matching fill_idx.
- After the fills above, request 0x33:
  - rsp_vld at 2 cycles after acceptance, rsp_hit=1, rsp_idx=2.
  - ref_vld pulses for one cycle with ref_buf_req=2.
  - fill_req stays 0.
- All 4 entries valid, request 0x55 with buf_num_replc=1:
  - new_buf_req pulses for exactly one cycle, then fill_idx=1, fill_tag=0x55.
  - After fill_ack: response rsp_hit=0, rsp_idx=1.
  - A subsequent request for 0x22 misses; a subsequent request for 0x55 hits at idx 1.
- Hold rsp_rdy=0 for 5 cycles on a hit:
  - rsp_vld, rsp_hit and rsp_idx stay stable; req_rdy stays 0.
  - A req_vld pulse during this time is not accepted.
- Assert rst_n=0 while fill_req=1:
  - fill_req drops immediately.
  - A later fill_ack produces no response.
  - After reset, request 0x11 misses and fills idx 0.
- Spurious fill_ack while in IDLE:
  - No state change, no valid bit set.

Source files
------------

// File: rtl/buf_req_ctrl.sv
// ---------------------------------------------------------------------------
// buf_req_ctrl
//
// Request front-end for the 4-entry buffer manager, sitting directly upstream
// of lfu_finder. It keeps one tag register and one valid bit per buffer and
// serves one tag lookup at a time:
//   - hit  : reports the buffer index to lfu_finder and responds with it
//   - miss : fills the lowest free buffer, or, when every buffer is in use,
//            asks lfu_finder for a victim, fills that buffer from memory and
//            responds with it
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   req_vld       in   lookup request valid
//   req_tag       in   tag to look up
//   req_rdy       out  block can accept a request (only while idle)
//   rsp_vld       out  response valid, held until rsp_rdy
//   rsp_hit       out  1 = hit, 0 = filled after miss
//   rsp_idx       out  buffer index serving the request
//   rsp_rdy       in   consumer accepts response
//   ref_vld       out  one-cycle pulse, hit reported to lfu_finder
//   ref_buf_req   out  index of last hit, holds between hits
//   new_buf_req   out  one-cycle pulse requesting an LFU victim
//   buf_num_replc in   victim index from lfu_finder
//   fill_req      out  memory fill request (level, held until fill_ack)
//   fill_tag      out  tag being filled
//   fill_idx      out  destination buffer of the fill
//   fill_ack      in   one-cycle fill completion
// ---------------------------------------------------------------------------
module buf_req_ctrl #(
   parameter int BUF_BIT = 2,
   parameter int TAG_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_vld,
   input  logic [TAG_W-1:0]   req_tag,
   output logic               req_rdy,
   output logic               rsp_vld,
   output logic               rsp_hit,
   output logic [BUF_BIT-1:0] rsp_idx,
   input  logic               rsp_rdy,
   output logic               ref_vld,
   output logic [BUF_BIT-1:0] ref_buf_req,
   output logic               new_buf_req,
   input  logic [BUF_BIT-1:0] buf_num_replc,
   output logic               fill_req,
   output logic [TAG_W-1:0]   fill_tag,
   output logic [BUF_BIT-1:0] fill_idx,
   input  logic               fill_ack
);

   localparam int NUM_BUF = 2 ** BUF_BIT;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      VICT,
      FILL,
      RESP
   } state_t;

   state_t state, state_nxt;

   // CHECK takes two cycles: the first registers the tag compare results,
   // the second acts on them, keeping the compare off the output path.
   logic cmp_done, cmp_done_nxt;

   logic [NUM_BUF-1:0][TAG_W-1:0] tags, tags_nxt;
   logic [NUM_BUF-1:0]            valid, valid_nxt;
   logic [TAG_W-1:0]              cur_tag, cur_tag_nxt;

   logic               hit_found, hit_found_nxt;
   logic [BUF_BIT-1:0] hit_idx, hit_idx_nxt;
   logic               free_found, free_found_nxt;
   logic [BUF_BIT-1:0] free_idx, free_idx_nxt;

   logic               req_rdy_nxt;
   logic               rsp_vld_nxt;
   logic               rsp_hit_nxt;
   logic [BUF_BIT-1:0] rsp_idx_nxt;
   logic               ref_vld_nxt;
   logic [BUF_BIT-1:0] ref_buf_req_nxt;
   logic               new_buf_req_nxt;
   logic               fill_req_nxt;
   logic [TAG_W-1:0]   fill_tag_nxt;
   logic [BUF_BIT-1:0] fill_idx_nxt;

   logic               hit_any;
   logic [BUF_BIT-1:0] hit_at;
   logic               free_any;
   logic [BUF_BIT-1:0] free_at;

   // Priority search over all entries. Scanning from the top down lets the
   // lowest matching index overwrite the others, so duplicates resolve to
   // the lowest index and the lowest invalid entry is the preferred free one.
   always_comb begin
      hit_any  = 1'b0;
      hit_at   = '0;
      free_any = 1'b0;
      free_at  = '0;
      for (int i = NUM_BUF - 1; i >= 0; i--) begin
         if (valid[i] && (tags[i] == cur_tag)) begin
            hit_any = 1'b1;
            hit_at  = BUF_BIT'(i);
         end
         if (!valid[i]) begin
            free_any = 1'b1;
            free_at  = BUF_BIT'(i);
         end
      end
   end

   // Next-state and next-output logic. Every output is registered, so this
   // block computes what each output register holds after the coming edge.
   // Pulse outputs default low; everything else holds its value.
   always_comb begin
      state_nxt       = state;
      cmp_done_nxt    = cmp_done;
      tags_nxt        = tags;
      valid_nxt       = valid;
      cur_tag_nxt     = cur_tag;
      hit_found_nxt   = hit_found;
      hit_idx_nxt     = hit_idx;
      free_found_nxt  = free_found;
      free_idx_nxt    = free_idx;
      req_rdy_nxt     = req_rdy;
      rsp_vld_nxt     = rsp_vld;
      rsp_hit_nxt     = rsp_hit;
      rsp_idx_nxt     = rsp_idx;
      ref_vld_nxt     = 1'b0;
      ref_buf_req_nxt = ref_buf_req;
      new_buf_req_nxt = 1'b0;
      fill_req_nxt    = fill_req;
      fill_tag_nxt    = fill_tag;
      fill_idx_nxt    = fill_idx;

      case (state)
         IDLE: begin
            if (req_vld && req_rdy) begin
               cur_tag_nxt  = req_tag;
               req_rdy_nxt  = 1'b0;
               cmp_done_nxt = 1'b0;
               state_nxt    = CHECK;
            end
         end

         CHECK: begin
            if (!cmp_done) begin
               cmp_done_nxt   = 1'b1;
               hit_found_nxt  = hit_any;
               hit_idx_nxt    = hit_at;
               free_found_nxt = free_any;
               free_idx_nxt   = free_at;
            end else if (hit_found) begin
               ref_vld_nxt     = 1'b1;
               ref_buf_req_nxt = hit_idx;
               rsp_hit_nxt     = 1'b1;
               rsp_idx_nxt     = hit_idx;
               rsp_vld_nxt     = 1'b1;
               state_nxt       = RESP;
            end else if (free_found) begin
               fill_req_nxt = 1'b1;
               fill_tag_nxt = cur_tag;
               fill_idx_nxt = free_idx;
               state_nxt    = FILL;
            end else begin
               new_buf_req_nxt = 1'b1;
               state_nxt       = VICT;
            end
         end

         // new_buf_req falls on this edge, which is also where lfu_finder's
         // answer is taken as the victim.
         VICT: begin
            fill_req_nxt = 1'b1;
            fill_tag_nxt = cur_tag;
            fill_idx_nxt = buf_num_replc;
            state_nxt    = FILL;
         end

         // The victim's old tag, if any, is simply overwritten.
         FILL: begin
            if (fill_ack) begin
               tags_nxt[fill_idx]  = cur_tag;
               valid_nxt[fill_idx] = 1'b1;
               fill_req_nxt        = 1'b0;
               rsp_hit_nxt         = 1'b0;
               rsp_idx_nxt         = fill_idx;
               rsp_vld_nxt         = 1'b1;
               state_nxt           = RESP;
            end
         end

         RESP: begin
            if (rsp_rdy) begin
               rsp_vld_nxt = 1'b0;
               req_rdy_nxt = 1'b1;
               state_nxt   = IDLE;
            end
         end

         default: begin
            state_nxt   = IDLE;
            req_rdy_nxt = 1'b1;
            rsp_vld_nxt = 1'b0;
            fill_req_nxt = 1'b0;
         end
      endcase
   end

   // State and output registers. Reset clears the table and drops any
   // in-flight fill request at once, abandoning the current request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cmp_done    <= 1'b0;
         tags        <= '0;
         valid       <= '0;
         cur_tag     <= '0;
         hit_found   <= 1'b0;
         hit_idx     <= '0;
         free_found  <= 1'b0;
         free_idx    <= '0;
         req_rdy     <= 1'b1;
         rsp_vld     <= 1'b0;
         rsp_hit     <= 1'b0;
         rsp_idx     <= '0;
         ref_vld     <= 1'b0;
         ref_buf_req <= '0;
         new_buf_req <= 1'b0;
         fill_req    <= 1'b0;
         fill_tag    <= '0;
         fill_idx    <= '0;
      end else begin
         state       <= state_nxt;
         cmp_done    <= cmp_done_nxt;
         tags        <= tags_nxt;
         valid       <= valid_nxt;
         cur_tag     <= cur_tag_nxt;
         hit_found   <= hit_found_nxt;
         hit_idx     <= hit_idx_nxt;
         free_found  <= free_found_nxt;
         free_idx    <= free_idx_nxt;
         req_rdy     <= req_rdy_nxt;
         rsp_vld     <= rsp_vld_nxt;
         rsp_hit     <= rsp_hit_nxt;
         rsp_idx     <= rsp_idx_nxt;
         ref_vld     <= ref_vld_nxt;
         ref_buf_req <= ref_buf_req_nxt;
         new_buf_req <= new_buf_req_nxt;
         fill_req    <= fill_req_nxt;
         fill_tag    <= fill_tag_nxt;
         fill_idx    <= fill_idx_nxt;
      end
   end

endmodule

// File: tb/tb_buf_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_buf_req_ctrl
//
// Self-checking bench for buf_req_ctrl. Directed scenarios walk the free-fill,
// hit, victim-replacement, response-stall, mid-fill reset and stray fill_ack
// cases, then a randomized run exercises the same paths. Expected results
// come from a plain table of (valid, tag) per buffer inside the bench.
// ---------------------------------------------------------------------------
module tb_buf_req_ctrl;

   localparam int BUF_BIT = 2;
   localparam int TAG_W   = 8;
   localparam int NUM_BUF = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               req_vld;
   logic [TAG_W-1:0]   req_tag;
   logic               req_rdy;
   logic               rsp_vld;
   logic               rsp_hit;
   logic [BUF_BIT-1:0] rsp_idx;
   logic               rsp_rdy;
   logic               ref_vld;
   logic [BUF_BIT-1:0] ref_buf_req;
   logic               new_buf_req;
   logic [BUF_BIT-1:0] buf_num_replc;
   logic               fill_req;
   logic [TAG_W-1:0]   fill_tag;
   logic [BUF_BIT-1:0] fill_idx;
   logic               fill_ack;

   int checks = 0;
   int errors = 0;
   int nbrPulses = 0;
   int refPulses = 0;

   logic [TAG_W-1:0] modelTag [NUM_BUF];
   bit               modelValid [NUM_BUF];

   buf_req_ctrl #(.BUF_BIT(BUF_BIT), .TAG_W(TAG_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_vld       (req_vld),
      .req_tag       (req_tag),
      .req_rdy       (req_rdy),
      .rsp_vld       (rsp_vld),
      .rsp_hit       (rsp_hit),
      .rsp_idx       (rsp_idx),
      .rsp_rdy       (rsp_rdy),
      .ref_vld       (ref_vld),
      .ref_buf_req   (ref_buf_req),
      .new_buf_req   (new_buf_req),
      .buf_num_replc (buf_num_replc),
      .fill_req      (fill_req),
      .fill_tag      (fill_tag),
      .fill_idx      (fill_idx),
      .fill_ack      (fill_ack)
   );

   // 10-time-unit clock.
   always #5 clk = ~clk;

   // Pulse counters sampled mid-cycle, used to prove single-cycle pulses.
   always @(negedge clk) begin
      if (new_buf_req) nbrPulses++;
      if (ref_vld)     refPulses++;
   end

   // One comparison: counts it, and on a mismatch counts and reports it.
   task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic clearModel();
      for (int i = 0; i < NUM_BUF; i++) begin
         modelValid[i] = 1'b0;
         modelTag[i]   = '0;
      end
   endtask

   // One complete lookup transaction. The expected outcome is worked out from
   // the bench's table first, then every cycle of the transaction is checked.
   task automatic applyStimulus(input logic [TAG_W-1:0] tag, input logic [BUF_BIT-1:0] victim,
                                input int ackDelay, input int rdyDelay, input bit pokeReq);
      bit               expHit;
      bit               expVict;
      bit               found;
      logic [BUF_BIT-1:0] expIdx;
      int               nbrStart;
      int               refStart;

      expHit  = 1'b0;
      expVict = 1'b0;
      found   = 1'b0;
      expIdx  = '0;
      for (int i = 0; i < NUM_BUF; i++) begin
         if (!expHit && modelValid[i] && modelTag[i] == tag) begin
            expHit = 1'b1;
            expIdx = BUF_BIT'(i);
         end
      end
      if (!expHit) begin
         for (int i = 0; i < NUM_BUF; i++) begin
            if (!found && !modelValid[i]) begin
               found  = 1'b1;
               expIdx = BUF_BIT'(i);
            end
         end
         if (!found) begin
            expVict = 1'b1;
            expIdx  = victim;
         end
      end

      @(negedge clk);
      checkOutput("req_rdy_idle", req_rdy, 1);
      req_vld       = 1'b1;
      req_tag       = tag;
      buf_num_replc = victim;
      nbrStart      = nbrPulses;
      refStart      = refPulses;

      @(negedge clk);
      req_vld = 1'b0;
      req_tag = TAG_W'($urandom);
      checkOutput("req_rdy_busy", req_rdy, 0);
      checkOutput("rsp_vld_k", rsp_vld, 0);

      @(negedge clk);
      checkOutput("rsp_vld_k1", rsp_vld, 0);
      checkOutput("new_buf_k1", new_buf_req, 0);
      checkOutput("fill_req_k1", fill_req, 0);

      @(negedge clk);
      if (expHit) begin
         checkOutput("hit_rsp_vld", rsp_vld, 1);
         checkOutput("hit_rsp_hit", rsp_hit, 1);
         checkOutput("hit_rsp_idx", rsp_idx, expIdx);
         checkOutput("hit_ref_vld", ref_vld, 1);
         checkOutput("hit_ref_buf", ref_buf_req, expIdx);
         checkOutput("hit_fill_req", fill_req, 0);
      end else begin
         checkOutput("miss_ref_vld", ref_vld, 0);
         checkOutput("miss_rsp_vld", rsp_vld, 0);
         if (expVict) begin
            checkOutput("vict_new_buf", new_buf_req, 1);
            checkOutput("vict_fill_req", fill_req, 0);
            @(negedge clk);
            buf_num_replc = ~victim;
            checkOutput("vict_new_buf_fall", new_buf_req, 0);
         end else begin
            checkOutput("free_new_buf", new_buf_req, 0);
         end
         checkOutput("fill_req", fill_req, 1);
         checkOutput("fill_idx", fill_idx, expIdx);
         checkOutput("fill_tag", fill_tag, tag);
         for (int c = 0; c < ackDelay; c++) begin
            @(negedge clk);
            checkOutput("fill_req_hold", fill_req, 1);
            checkOutput("fill_idx_hold", fill_idx, expIdx);
            checkOutput("rsp_vld_fill", rsp_vld, 0);
         end
         fill_ack = 1'b1;
         @(negedge clk);
         fill_ack = 1'b0;
         checkOutput("fill_req_drop", fill_req, 0);
         checkOutput("fill_rsp_vld", rsp_vld, 1);
         checkOutput("fill_rsp_hit", rsp_hit, 0);
         checkOutput("fill_rsp_idx", rsp_idx, expIdx);
         modelTag[expIdx]   = tag;
         modelValid[expIdx] = 1'b1;
      end

      for (int c = 0; c < rdyDelay; c++) begin
         if (pokeReq && c == 1) begin
            req_vld = 1'b1;
            req_tag = TAG_W'($urandom);
         end
         @(negedge clk);
         req_vld = 1'b0;
         checkOutput("stall_rsp_vld", rsp_vld, 1);
         checkOutput("stall_rsp_hit", rsp_hit, expHit);
         checkOutput("stall_rsp_idx", rsp_idx, expIdx);
         checkOutput("stall_req_rdy", req_rdy, 0);
      end

      rsp_rdy = 1'b1;
      @(negedge clk);
      rsp_rdy = 1'b0;
      checkOutput("rsp_done_vld", rsp_vld, 0);
      checkOutput("rsp_done_rdy", req_rdy, 1);
      checkOutput("ref_pulse_count", refPulses - refStart, expHit ? 1 : 0);
      checkOutput("nbr_pulse_count", nbrPulses - nbrStart, expVict ? 1 : 0);
   endtask

   // Directed scenarios followed by a randomized run, all in one sequence.
   initial begin
      rst_n         = 1'b1;
      req_vld       = 1'b0;
      req_tag       = '0;
      rsp_rdy       = 1'b0;
      buf_num_replc = '0;
      fill_ack      = 1'b0;
      clearModel();

      // Reset acts before any clock edge.
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_req_rdy", req_rdy, 1);
      checkOutput("rst_rsp_vld", rsp_vld, 0);
      checkOutput("rst_rsp_hit", rsp_hit, 0);
      checkOutput("rst_rsp_idx", rsp_idx, 0);
      checkOutput("rst_ref_vld", ref_vld, 0);
      checkOutput("rst_ref_buf", ref_buf_req, 0);
      checkOutput("rst_new_buf", new_buf_req, 0);
      checkOutput("rst_fill_req", fill_req, 0);
      checkOutput("rst_fill_tag", fill_tag, 0);
      checkOutput("rst_fill_idx", fill_idx, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Four misses fill free buffers 0..3 without asking for a victim.
      applyStimulus(8'h11, 2'd3, 3, 0, 1'b0);
      applyStimulus(8'h22, 2'd3, 3, 0, 1'b0);
      applyStimulus(8'h33, 2'd3, 3, 0, 1'b0);
      applyStimulus(8'h44, 2'd3, 3, 0, 1'b0);
      checkOutput("no_victim_during_fills", nbrPulses, 0);

      // Hit on a resident tag.
      applyStimulus(8'h33, 2'd0, 0, 0, 1'b0);

      // Table full: victim replacement, then the evicted tag misses and the
      // new one hits (here with a stalled response and an ignored request).
      applyStimulus(8'h55, 2'd1, 2, 0, 1'b0);
      applyStimulus(8'h22, 2'd3, 1, 0, 1'b0);
      applyStimulus(8'h55, 2'd0, 0, 5, 1'b1);

      // Reset while a fill is outstanding.
      @(negedge clk);
      req_vld       = 1'b1;
      req_tag       = 8'h77;
      buf_num_replc = 2'd2;
      @(negedge clk);
      req_vld = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("fill_before_rst", fill_req, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_fill_req", fill_req, 0);
      checkOutput("rst_mid_req_rdy", req_rdy, 1);
      checkOutput("rst_mid_rsp_vld", rsp_vld, 0);
      clearModel();
      @(negedge clk);
      rst_n = 1'b1;

      // Late fill_ack after reset, while idle, must do nothing.
      @(negedge clk);
      fill_ack = 1'b1;
      @(negedge clk);
      fill_ack = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("stray_ack_rsp_vld", rsp_vld, 0);
      checkOutput("stray_ack_fill_req", fill_req, 0);
      checkOutput("stray_ack_req_rdy", req_rdy, 1);

      // Table was emptied by reset and untouched by the stray ack.
      applyStimulus(8'h11, 2'd3, 1, 0, 1'b0);
      applyStimulus(8'h00, 2'd3, 1, 0, 1'b0);

      // Randomized traffic over a small tag pool so hits and evictions mix.
      for (int n = 0; n < 40; n++) begin
         applyStimulus(TAG_W'(8'hA0 + $urandom_range(0, 9)),
                       BUF_BIT'($urandom_range(0, NUM_BUF - 1)),
                       int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 2)),
                       1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
